// File: rtl/nonce_report_fifo.sv
// nonce_report_fifo: queues golden nonces and frames each as SYNC, 4 nonce bytes (big-endian), XOR checksum
module nonce_report_fifo #(
  parameter int DEPTH = 4,
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     nonce_valid,
  input  logic [31:0]              nonce_in,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  input  logic                     clear_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [2:0] {IDLE, HDR, B3, B2, B1, B0, CHK} state_t;
  state_t          r_state;
  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [31:0]     r_frame;
  logic [7:0]      r_chk;
  logic            w_pop, w_push, w_drop;
  logic [31:0]     w_head;
  assign w_pop  = (r_state == IDLE) && (fifo_count != '0);
  assign w_push = nonce_valid && ((fifo_count < FULL) || w_pop);
  assign w_drop = nonce_valid && !w_push;
  assign w_head = r_mem[r_rd];
  // storage array carries no reset; only pointers and count define what is valid
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= nonce_in;
  // pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      fifo_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      fifo_count <= fifo_count + CW'(w_push) - CW'(w_pop);
    end
  // sticky loss flag and saturating drop counter; a drop outranks a simultaneous clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      overflow <= 1'b0;
      drop_count <= '0;
    end else if (w_drop) begin
      overflow <= 1'b1;
      drop_count <= clear_overflow ? 8'd1 : (drop_count == 8'hFF ? 8'hFF : drop_count + 8'd1);
    end else if (clear_overflow) begin
      overflow <= 1'b0;
      drop_count <= '0;
    end
  // frame serialiser: each state presents one byte and advances only on handshake
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_frame <= '0;
      r_chk <= '0;
      tx_valid <= 1'b0;
      tx_data <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_pop) begin
          r_frame <= w_head;
          r_chk <= w_head[31:24] ^ w_head[23:16] ^ w_head[15:8] ^ w_head[7:0];
          r_state <= HDR;
          tx_valid <= 1'b1;
          tx_data <= SYNC;
        end
        HDR: if (tx_ready) begin r_state <= B3; tx_data <= r_frame[31:24]; end
        B3:  if (tx_ready) begin r_state <= B2; tx_data <= r_frame[23:16]; end
        B2:  if (tx_ready) begin r_state <= B1; tx_data <= r_frame[15:8]; end
        B1:  if (tx_ready) begin r_state <= B0; tx_data <= r_frame[7:0]; end
        B0:  if (tx_ready) begin r_state <= CHK; tx_data <= r_chk; end
        CHK: if (tx_ready) begin r_state <= IDLE; tx_valid <= 1'b0; tx_data <= '0; end
        default: begin r_state <= IDLE; tx_valid <= 1'b0; tx_data <= '0; end
      endcase
    end
endmodule
